// File: rtl/gameshow_answer_timer.sv
// Answer timer after the buzzer lockout stage: encodes the winner, counts down on a 7-seg digit,
// sounds chirp/alarm tones and requests the buzzer clear. Define GAMESHOW_AUTOCLEAR_EN to auto-clear after one alarm second.
module gameshow_answer_timer #(
  parameter int unsigned TICKS_PER_SEC = 1000,
  parameter int unsigned ANSWER_SECS   = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] lockout,
  input  logic       host_clear,
  output logic [6:0] seg,
  output logic [2:0] player,
  output logic       tone,
  output logic       timeout,
  output logic       buzzer_clr
);

  localparam int unsigned TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICKS_PER_SEC - 1);
  localparam logic [TICK_W-1:0] TICK_CHIRP = TICK_W'(TICKS_PER_SEC / 4);
  localparam logic [TICK_W-1:0] TICK_HALF  = TICK_W'(TICKS_PER_SEC / 2);
  localparam logic [3:0]        SECS_START = 4'(ANSWER_SECS);
  localparam logic [6:0]        SEG_DASH   = 7'h40;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COUNT   = 2'd1,
    EXPIRED = 2'd2,
    CLEAR   = 2'd3
  } state_t;

  state_t            state;
  logic [3:0]        secs;
  logic [TICK_W-1:0] tick;
  logic [2:0]        win;
  logic              clr_cnt;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Lowest set bit wins when several players land in the same cycle.
  function automatic logic [2:0] first_player(input logic [5:0] v);
    logic [2:0] p;
    p = 3'd0;
    for (int i = 5; i >= 0; i--) begin
      if (v[i]) p = 3'(i + 1);
    end
    return p;
  endfunction

  wire tick_wrap = (tick == TICK_LAST);

  // Outputs are registered from the current state, so they trail the state by one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      secs       <= 4'd0;
      tick       <= '0;
      win        <= 3'd0;
      clr_cnt    <= 1'b0;
      seg        <= SEG_DASH;
      player     <= 3'd0;
      tone       <= 1'b0;
      timeout    <= 1'b0;
      buzzer_clr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          seg        <= SEG_DASH;
          player     <= 3'd0;
          tone       <= 1'b0;
          timeout    <= 1'b0;
          buzzer_clr <= 1'b0;
        end
        COUNT: begin
          seg        <= seg_digit(secs);
          player     <= win;
          tone       <= (secs == SECS_START) && (tick < TICK_CHIRP);
          timeout    <= 1'b0;
          buzzer_clr <= 1'b0;
        end
        EXPIRED: begin
          seg        <= seg_digit(4'd0);
          player     <= win;
          tone       <= (tick < TICK_HALF);
          timeout    <= 1'b1;
          buzzer_clr <= 1'b0;
        end
        CLEAR: begin
          seg        <= seg;
          player     <= player;
          tone       <= 1'b0;
          timeout    <= 1'b0;
          buzzer_clr <= 1'b1;
        end
      endcase

      case (state)
        IDLE: begin
          tick    <= '0;
          clr_cnt <= 1'b0;
          if (lockout != 6'd0) begin
            state <= COUNT;
            win   <= first_player(lockout);
            secs  <= SECS_START;
          end
        end
        COUNT: begin
          if (host_clear) begin
            state   <= CLEAR;
            clr_cnt <= 1'b0;
          end else if (lockout == 6'd0) begin
            state <= IDLE;
          end else begin
            tick <= tick_wrap ? '0 : tick + TICK_W'(1);
            if (tick_wrap) begin
              if (secs <= 4'd1) begin
                state <= EXPIRED;
                secs  <= 4'd0;
              end else begin
                secs <= secs - 4'd1;
              end
            end
          end
        end
        EXPIRED: begin
          if (host_clear) begin
            state   <= CLEAR;
            clr_cnt <= 1'b0;
          end else if (lockout == 6'd0) begin
            state <= IDLE;
          end else begin
            tick <= tick_wrap ? '0 : tick + TICK_W'(1);
`ifdef GAMESHOW_AUTOCLEAR_EN
            if (tick_wrap) begin
              state   <= CLEAR;
              clr_cnt <= 1'b0;
            end
`endif
          end
        end
        CLEAR: begin
          // Hold the clear request for two cycles minimum and until the buzzer stage releases.
          clr_cnt <= 1'b1;
          if (clr_cnt && (lockout == 6'd0)) state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gameshow_answer_timer.sv
// Directed bench for gameshow_answer_timer with TICKS_PER_SEC=8, ANSWER_SECS=3.
module tb_gameshow_answer_timer;

  logic       clk;
  logic       rst;
  logic [5:0] lockout;
  logic       host_clear;
  logic [6:0] seg;
  logic [2:0] player;
  logic       tone;
  logic       timeout;
  logic       buzzer_clr;

  int vectors;
  int miscompares;

  gameshow_answer_timer #(
    .TICKS_PER_SEC(8),
    .ANSWER_SECS  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .lockout   (lockout),
    .host_clear(host_clear),
    .seg       (seg),
    .player    (player),
    .tone      (tone),
    .timeout   (timeout),
    .buzzer_clr(buzzer_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_seg"}, {1'b0, seg}, 8'h40);
    chk({tag, "_player"}, {5'd0, player}, 8'd0);
    chk({tag, "_tone"}, {7'd0, tone}, 8'd0);
    chk({tag, "_timeout"}, {7'd0, timeout}, 8'd0);
    chk({tag, "_bclr"}, {7'd0, buzzer_clr}, 8'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    lockout     = 6'd0;
    host_clear  = 1'b0;
    step(2);
    rst = 1'b0;
    chk_idle("reset");

    // host_clear while idle does nothing
    host_clear = 1'b1;
    step(2);
    host_clear = 1'b0;
    chk_idle("idle_hclr");

    // Player 3 locks out: full countdown
    lockout = 6'b000100;
    step(1);
    chk("lock_lat_seg", {1'b0, seg}, 8'h40);
    step(1);
    chk("p3_player", {5'd0, player}, 8'd3);
    chk("p3_seg3", {1'b0, seg}, 8'h4F);
    chk("chirp0", {7'd0, tone}, 8'd1);
    step(1);
    chk("chirp1", {7'd0, tone}, 8'd1);
    step(1);
    chk("chirp_end", {7'd0, tone}, 8'd0);
    step(5);
    chk("seg3_hold", {1'b0, seg}, 8'h4F);
    step(1);
    chk("seg2", {1'b0, seg}, 8'h5B);
    chk("tone_sec2", {7'd0, tone}, 8'd0);
    step(7);
    chk("seg2_hold", {1'b0, seg}, 8'h5B);
    step(1);
    chk("seg1", {1'b0, seg}, 8'h06);
    step(7);
    chk("seg1_hold", {1'b0, seg}, 8'h06);
    chk("timeout_pre", {7'd0, timeout}, 8'd0);
    step(1);
    chk("seg0", {1'b0, seg}, 8'h3F);
    chk("timeout_set", {7'd0, timeout}, 8'd1);
    chk("exp_player", {5'd0, player}, 8'd3);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("alarm_%0d", k), {7'd0, tone}, (k < 4) ? 8'd1 : 8'd0);
      if (k < 7) step(1);
    end

`ifdef GAMESHOW_AUTOCLEAR_EN
    step(1);
    chk("auto_bclr", {7'd0, buzzer_clr}, 8'd1);
    chk("auto_timeout", {7'd0, timeout}, 8'd0);
`else
    step(100);
    chk("hold_timeout", {7'd0, timeout}, 8'd1);
    chk("hold_bclr", {7'd0, buzzer_clr}, 8'd0);
    host_clear = 1'b1;
    step(1);
    host_clear = 1'b0;
    chk("hclr_lat", {7'd0, buzzer_clr}, 8'd0);
    step(1);
    chk("hclr_bclr", {7'd0, buzzer_clr}, 8'd1);
    chk("hclr_timeout", {7'd0, timeout}, 8'd0);
    chk("hclr_tone", {7'd0, tone}, 8'd0);
`endif
    chk("clr_player", {5'd0, player}, 8'd3);
    chk("clr_seg", {1'b0, seg}, 8'h3F);
    step(3);
    chk("clr_held", {7'd0, buzzer_clr}, 8'd1);
    lockout = 6'd0;
    step(1);
    chk("clr_last", {7'd0, buzzer_clr}, 8'd1);
    step(1);
    chk_idle("clr_done");

    // Simultaneous presses, then external clear via lockout falling
    lockout = 6'b101010;
    step(2);
    chk("multi_player", {5'd0, player}, 8'd2);
    chk("multi_seg", {1'b0, seg}, 8'h4F);
    lockout = 6'd0;
    step(1);
    chk("ext_lat", {5'd0, player}, 8'd2);
    step(1);
    chk_idle("ext_clr");

    // host_clear coincides with the final second wrap
    lockout = 6'b100000;
    step(1);
    step(23);
    chk("wrap_seg1", {1'b0, seg}, 8'h06);
    host_clear = 1'b1;
    step(1);
    host_clear = 1'b0;
    chk("wrap_timeout0", {7'd0, timeout}, 8'd0);
    step(1);
    chk("wrap_bclr", {7'd0, buzzer_clr}, 8'd1);
    chk("wrap_player", {5'd0, player}, 8'd6);
    chk("wrap_seg_held", {1'b0, seg}, 8'h06);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("wrap_no_to_%0d", k), {7'd0, timeout}, 8'd0);
      step(1);
    end
    lockout = 6'd0;
    step(2);
    chk_idle("wrap_done");

    // Reset in the middle of a countdown
    lockout = 6'b000001;
    step(2);
    chk("p1_player", {5'd0, player}, 8'd1);
    step(3);
    rst = 1'b1;
    #1;
    chk_idle("mid_rst");
    lockout = 6'd0;
    step(2);
    rst = 1'b0;
    step(3);
    chk_idle("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/gameshow_answer_timer.md
# gameshow_answer_timer

Downstream stage of the gameshow buzzer lockout register. Consumes the 6-bit one-hot-ish lockout vector and encodes the winning player. Runs a per-answer countdown shown on a 7-segment digit, sounds a lock chirp and a timeout alarm, and issues the clear request that re-arms the buzzer stage for the next question.

## Interface
- TICKS_PER_SEC, 1000: clock cycles per countdown second; must be ≥ 8 and divisible by 8.
- ANSWER_SECS, 9: countdown start value; legal range 1..9.

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- lockout  in  6  lockout vector from the buzzer stage (bit i = player i+1)
- host_clear  in  1  host "next question" button, synchronous level
- seg  out  7  7-seg pattern, bit0=a … bit6=g, active-high
- player  out  3  winning player 1..6, 0 when none
- tone  out  1  piezo enable
- timeout  out  1  high while answer time expired
- buzzer_clr  out  1  clear request to the buzzer stage (drives its rst)

Clock is one clock; reset is asynchronous and active-high, ports named clk and rst.

## Operation
- States: IDLE, COUNT, EXPIRED, CLEAR.
- IDLE: seg = 7'h40 (dash), player = 0, tone = 0, timeout = 0. On lockout != 0 -> COUNT; player <= index of lowest set bit + 1 (simultaneous presses: lowest index wins); secs <= ANSWER_SECS; tick <= 0.
- COUNT: seg = digit(secs). tick counts 0..TICKS_PER_SEC-1; at wrap secs decrements. Transition from secs==1 at wrap -> EXPIRED (secs=0). tone = 1 while (secs==ANSWER_SECS and tick < TICKS_PER_SEC/4) (lock chirp).
- EXPIRED: seg = digit(0), timeout = 1, tone = 1 when tick < TICKS_PER_SEC/2 (1 Hz alarm); tick keeps free-running.
- host_clear high in COUNT or EXPIRED -> CLEAR (priority over the countdown transition in the same cycle).
- CLEAR: buzzer_clr = 1; player, seg held; tone = 0, timeout = 0. Stay at least 2 cycles and until lockout == 0, then -> IDLE.
- lockout returning to 0 while in COUNT or EXPIRED (external clear): -> IDLE next cycle.
- host_clear in IDLE/CLEAR ignored.
- Digit encoding: 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex).
- tick width = clog2(TICKS_PER_SEC); secs width = 4.

## Timing
- All outputs registered; reset values: state IDLE, seg 7'h40, player 0, tone 0, timeout 0, buzzer_clr 0, secs 0, tick 0.
- Lockout seen at edge N -> player/seg valid and tone = 1 after edge N+1.
- First decrement at TICKS_PER_SEC cycles after COUNT entry; EXPIRED entered ANSWER_SECS*TICKS_PER_SEC cycles after COUNT entry.
- host_clear sampled at edge N -> buzzer_clr = 1 after edge N+1; minimum pulse 2 cycles; IDLE one cycle after the first CLEAR cycle ≥ 2 where lockout == 0.
- rst mid-operation: immediate return to reset values, no buzzer_clr pulse.

## Configuration
- GAMESHOW_AUTOCLEAR_EN defined: EXPIRED automatically moves to CLEAR after exactly TICKS_PER_SEC cycles (one alarm second) if host_clear not pressed.
- Undefined: EXPIRED holds indefinitely until host_clear or lockout falls to 0.

## Test plan
(TICKS_PER_SEC=8, ANSWER_SECS=3)
- Reset, lockout=0 -> seg=40, player=0, all other outputs 0; assert rst mid-COUNT -> same values immediately.
- lockout=6'b000100 -> next cycle player=3, seg=4F, tone=1 for 2 cycles then 0; seg=5B after 8 cycles, 06 after 16, 3F with timeout=1 after 24.
- lockout=6'b101010 in one cycle -> player=2.
- EXPIRED: tone pattern 1111 0000 repeating; host_clear pulse -> buzzer_clr=1 next cycle, held while lockout!=0, drop lockout -> IDLE, seg=40, player=0.
- host_clear in same cycle as secs 1->0 wrap -> CLEAR, timeout never asserted.
- With GAMESHOW_AUTOCLEAR_EN: EXPIRED for 8 cycles then buzzer_clr=1 without host_clear; without it: EXPIRED still after 100 cycles.
